pi_map: RTL and testbench

Clock-domain address decoder and data mover sitting directly downstream of the MCU serial interface. It consumes the `PiBus` strobes (`we_sync`/`oe_sync`, `addr`, `dato`) and routes each byte access to one of three targets: a control register file, a 1 KiB internal BRAM, or an external memory controller over a req/ack handshake. It returns read data on `dati` to the serial interface before that interface samples it.

---
 rtl/pi_map_pkg.sv | 31 +++
 rtl/pi_pkg.sv | 11 +
 rtl/pi_map_bram.sv | 24 ++
 rtl/pi_map.sv | 158 +++++++++++++++
 tb/tb_pi_map.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pi_map_pkg.sv
// Address map, FSM states and pending-request type for the pi_map decoder.
package pi_map_pkg;

    // EXT starts at address 0, so only its upper limit is needed.
    localparam logic [31:0] EXT_LIMIT  = 32'h00FF_FFFF;
    localparam logic [31:0] BRAM_BASE  = 32'h0100_0000;
    localparam logic [31:0] BRAM_LIMIT = 32'h0100_03FF;
    localparam logic [31:0] REG_BASE   = 32'h0180_0000;
    localparam logic [31:0] REG_LIMIT  = 32'h0180_000F;

    localparam logic [3:0] REG_ERR  = 4'hE;
    localparam logic [3:0] REG_ID   = 4'hF;
    localparam int         NUM_CTRL = 14;

    typedef enum logic [1:0] {RGN_EXT, RGN_BRAM, RGN_REG, RGN_UNMAPPED} region_e;
    typedef enum logic [1:0] {ST_IDLE, ST_BRAM_RD, ST_EXT} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  dato;
        logic        we;
    } pend_t;

    function automatic region_e region_of(input logic [31:0] a);
        if (a <= EXT_LIMIT)                          return RGN_EXT;
        else if (a >= BRAM_BASE && a <= BRAM_LIMIT)  return RGN_BRAM;
        else if (a >= REG_BASE && a <= REG_LIMIT)    return RGN_REG;
        else                                         return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/pi_pkg.sv
// Shared serial-interface bus definitions used by blocks downstream of the MCU SPI slave.
package pi_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  dato;
        logic        we_sync;
        logic        oe_sync;
    } PiBus;

endpackage

// File: rtl/pi_map_bram.sv
// 1024x8 single-port synchronous RAM, 1-cycle read latency, write-first.
module pi_map_bram (
    input  logic       clk,
    input  logic       en,
    input  logic       we,
    input  logic [9:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] mem [0:1023];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout      <= din;
            end else begin
                dout      <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/pi_map.sv
// Decodes PiBus strobes into control-register, BRAM and external-memory accesses.
module pi_map
    import pi_map_pkg::*;
#(
    parameter int         TIMEOUT = 64,
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    input  pi_pkg::PiBus   pi,
    output logic [7:0]     dati,
    output logic           mem_req,
    input  logic           mem_ack,
    output logic           mem_we,
    output logic           mem_oe,
    output logic [23:0]    mem_addr,
    output logic [7:0]     mem_dato,
    input  logic [7:0]     mem_dati,
    output logic [111:0]   ctrl_regs
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                       state_q, state_d;
    pend_t                        pend_q, serve, pulse_req;
    logic                         pend_vld_q;
    logic [NUM_CTRL-1:0][7:0]     regs;
    logic [7:0]                   err_cnt;
    logic [TW-1:0]                tcnt;
    logic                         pulse, serve_vld, timeout, drop;
    logic [3:0]                   idx;
    logic [7:0]                   reg_rd, ram_q;
    logic [1:0]                   err_inc;
    logic [8:0]                   err_sum;
    region_e                      rgn;

    assign pulse     = pi.we_sync | pi.oe_sync;
    // A simultaneous we/oe is treated as a write; the read is silently lost.
    assign pulse_req = '{addr: pi.addr, dato: pi.dato, we: pi.we_sync};

    // The pending slot takes priority so requests are served in arrival order.
    assign serve_vld = (state_q == ST_IDLE) && (pend_vld_q || pulse);
    assign serve     = pend_vld_q ? pend_q : pulse_req;
    assign rgn       = region_of(serve.addr);
    assign idx       = serve.addr[3:0];

    assign timeout = (state_q == ST_EXT) && !mem_ack && (tcnt == TW'(TIMEOUT - 1));
    assign drop    = pulse && (state_q != ST_IDLE) && pend_vld_q;
    assign err_inc = {1'b0, timeout} + {1'b0, drop};
    assign err_sum = {1'b0, err_cnt} + {7'd0, err_inc};

    always_comb begin
        reg_rd = 8'h00;
        if (idx == REG_ERR)     reg_rd = err_cnt;
        else if (idx == REG_ID) reg_rd = ID_BYTE;
        else                    reg_rd = regs[idx];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (serve_vld) begin
                    if (rgn == RGN_EXT)                     state_d = ST_EXT;
                    else if (rgn == RGN_BRAM && !serve.we)  state_d = ST_BRAM_RD;
                end
            end
            ST_BRAM_RD: state_d = ST_IDLE;
            ST_EXT:     if (mem_ack || timeout) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else if (state_q == ST_IDLE) begin
            // Slot is being drained this cycle, so a new pulse can refill it.
            pend_vld_q <= pend_vld_q && pulse;
            if (pend_vld_q && pulse) pend_q <= pulse_req;
        end else if (pulse && !pend_vld_q) begin
            pend_vld_q <= 1'b1;
            pend_q     <= pulse_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dati     <= 8'hFF;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_addr <= '0;
            mem_dato <= '0;
            regs     <= '0;
            err_cnt  <= '0;
            tcnt     <= '0;
        end else begin
            if (serve_vld && rgn == RGN_REG && serve.we && idx == REG_ERR)
                err_cnt <= '0;
            else if (err_inc != 2'd0)
                err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];

            case (state_q)
                ST_IDLE: begin
                    if (serve_vld) begin
                        case (rgn)
                            RGN_REG: begin
                                if (!serve.we)                        dati      <= reg_rd;
                                else if (idx < 4'(NUM_CTRL))          regs[idx] <= serve.dato;
                            end
                            RGN_UNMAPPED: if (!serve.we) dati <= 8'hFF;
                            RGN_EXT: begin
                                mem_req  <= 1'b1;
                                mem_we   <= serve.we;
                                mem_oe   <= !serve.we;
                                mem_addr <= serve.addr[23:0];
                                mem_dato <= serve.dato;
                                tcnt     <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BRAM_RD: dati <= ram_q;
                ST_EXT: begin
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_oe  <= 1'b0;
                        if (mem_oe) dati <= mem_ack ? mem_dati : 8'hFF;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pi_map_bram u_bram (
        .clk  (clk),
        .en   (serve_vld && rgn == RGN_BRAM),
        .we   (serve.we),
        .addr (serve.addr[9:0]),
        .din  (serve.dato),
        .dout (ram_q)
    );

    assign ctrl_regs = regs;

endmodule

// File: tb/tb_pi_map.sv
// Directed-vector bench for pi_map: register file, BRAM, EXT handshake, timeout, pending slot, reset.
module tb_pi_map;
    import pi_map_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    pi_pkg::PiBus   pi;
    logic [7:0]     dati;
    logic           mem_req, mem_ack, mem_we, mem_oe;
    logic [23:0]    mem_addr;
    logic [7:0]     mem_dato, mem_dati;
    logic [111:0]   ctrl_regs;

    int n_cmp = 0;
    int n_bad = 0;

    pi_map #(.TIMEOUT(64), .ID_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .pi        (pi),
        .dati      (dati),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_dato  (mem_dato),
        .mem_dati  (mem_dati),
        .ctrl_regs (ctrl_regs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle sync pulse; returns 1 ns after the edge that ends the pulse cycle (T+1).
    task automatic strobe(input logic we, input logic oe, input logic [31:0] a, input logic [7:0] d);
        pi.addr    = a;
        pi.dato    = d;
        pi.we_sync = we;
        pi.oe_sync = oe;
        tick();
        pi.we_sync = 1'b0;
        pi.oe_sync = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        mem_ack  = 1'b1;
        mem_dati = d;
        tick();
        mem_ack  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pi  = '0;
        mem_ack  = 1'b0;
        mem_dati = 8'h00;
        tick(); tick();
        rst = 1'b0;

        chk("rst_dati", dati, 8'hFF);
        chk("rst_req", {mem_req, mem_we, mem_oe}, 3'b000);
        chk("rst_addr", {mem_addr, mem_dato}, 32'h0);
        chk("rst_ctrl", ctrl_regs, 112'h0);

        strobe(1, 0, 32'h0180_0005, 8'h3C);
        chk("reg_wr", ctrl_regs[47:40], 8'h3C);
        tick();
        strobe(0, 1, 32'h0180_0005, 8'h00);
        chk("reg_rd", dati, 8'h3C);
        tick();
        strobe(0, 1, 32'h0180_000F, 8'h00);
        chk("id_rd", dati, 8'hA5);
        tick();

        strobe(1, 0, 32'h0100_0000, 8'h22);
        tick();
        strobe(1, 0, 32'h0100_03FF, 8'h11);
        tick();
        strobe(0, 1, 32'h0100_03FF, 8'h00);
        chk("bram_t1_hold", dati, 8'hA5);
        tick();
        chk("bram_rd_3ff", dati, 8'h11);
        strobe(0, 1, 32'h0100_0000, 8'h00);
        chk("bram_t1_hold2", dati, 8'h11);
        tick();
        chk("bram_rd_000", dati, 8'h22);

        strobe(0, 1, 32'h0012_3456, 8'h00);
        chk("ext_rd_req", {mem_req, mem_we, mem_oe}, 3'b101);
        chk("ext_rd_addr", mem_addr, 24'h123456);
        for (int i = 0; i < 4; i++) tick();
        chk("ext_rd_hold", {mem_req, mem_oe, mem_addr}, {2'b11, 24'h123456});
        ack(8'h9E);
        chk("ext_rd_dati", dati, 8'h9E);
        chk("ext_rd_drop", {mem_req, mem_oe}, 2'b00);

        strobe(1, 0, 32'h0000_0010, 8'h5A);
        chk("ext_wr_req", {mem_req, mem_we, mem_oe, mem_addr, mem_dato}, {3'b110, 24'h000010, 8'h5A});
        tick();
        ack(8'h33);
        chk("ext_wr_done", {mem_req, dati}, {1'b0, 8'h9E});

        strobe(0, 1, 32'h0000_00AB, 8'h00);
        for (int i = 0; i < 63; i++) tick();
        chk("to_req_c64", mem_req, 1'b1);
        tick();
        chk("to_req_c65", mem_req, 1'b0);
        chk("to_dati", dati, 8'hFF);
        ack(8'h77);
        chk("late_ack", {mem_req, dati}, {1'b0, 8'hFF});
        strobe(0, 1, 32'h0180_000E, 8'h00);
        chk("err_after_to", dati, 8'h01);
        tick();
        strobe(1, 0, 32'h0180_000E, 8'h00);
        tick();
        strobe(0, 1, 32'h0180_000E, 8'h00);
        chk("err_cleared", dati, 8'h00);
        tick();

        strobe(0, 1, 32'h0000_0100, 8'h00);
        strobe(1, 0, 32'h0180_0003, 8'h77);
        strobe(1, 0, 32'h0180_0004, 8'h88);
        tick();
        chk("pend_wait", ctrl_regs[31:24], 8'h00);
        ack(8'h44);
        chk("pend_ext_dati", dati, 8'h44);
        tick();
        chk("pend_served", ctrl_regs[31:24], 8'h77);
        chk("third_dropped", ctrl_regs[39:32], 8'h00);
        strobe(0, 1, 32'h0180_000E, 8'h00);
        chk("err_drop", dati, 8'h01);
        tick();

        strobe(1, 1, 32'h0180_0006, 8'h99);
        chk("we_oe_wr", ctrl_regs[55:48], 8'h99);
        chk("we_oe_no_rd", dati, 8'h01);
        tick();

        strobe(0, 1, 32'h0200_0000, 8'h00);
        chk("unmapped_rd", dati, 8'hFF);
        tick();

        strobe(0, 1, 32'h0000_0200, 8'h00);
        tick();
        chk("rst_mid_pre", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_mid_mem", {mem_req, mem_we, mem_oe, mem_addr, mem_dato}, 35'h0);
        chk("rst_mid_regs", {dati, ctrl_regs}, {8'hFF, 112'h0});
        rst = 1'b0;
        tick();
        strobe(0, 1, 32'h0180_000E, 8'h00);
        chk("rst_mid_noerr", dati, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
